// File: rtl/mul_arb.sv
// Two-requester round-robin front end for a shared 32-bit M-extension multiplier.
// Operands are registered in S1 (_p1) and results in S2 (_p2); each result returns to its issuer with its tag.
module mul_arb #(
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][31:0]      req_a,
    input  logic [1:0][31:0]      req_b,
    input  logic [1:0][2:0]       req_mulop,
    input  logic [1:0][TAG_W-1:0] req_tag,
    input  logic [1:0]            flush,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [31:0]           resp_data,
    output logic [TAG_W-1:0]      resp_tag
);
    localparam logic [2:0] MUL_OP     = 3'd0;
    localparam logic [2:0] MUL_OP_H   = 3'd1;
    localparam logic [2:0] MUL_OP_HSU = 3'd2;
    localparam logic [2:0] MUL_OP_HU  = 3'd3;

    function automatic logic [31:0] mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
        logic               sa_s, sb_s;
        logic signed [32:0] sa, sb;
        logic signed [63:0] p;
        case (op)
            MUL_OP_H:   begin sa_s = 1'b1; sb_s = 1'b1; end
            MUL_OP_HSU: begin sa_s = 1'b1; sb_s = 1'b0; end
            MUL_OP_HU:  begin sa_s = 1'b0; sb_s = 1'b0; end
            default:    begin sa_s = 1'b0; sb_s = 1'b0; end
        endcase
        sa = {sa_s & a[31], a};
        sb = {sb_s & b[31], b};
        p  = sa * sb;
        mul = (op == MUL_OP) ? p[31:0] : p[63:32];
    endfunction

    logic             vld_p1_q, vld_p1_d, own_p1_q, own_p1_d;
    logic [31:0]      a_p1_q, a_p1_d, b_p1_q, b_p1_d;
    logic [2:0]       op_p1_q, op_p1_d;
    logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
    logic             vld_p2_q, vld_p2_d, own_p2_q, own_p2_d;
    logic [31:0]      res_p2_q, res_p2_d;
    logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
    logic             last_q, last_d;
    logic             stall, accept_ok, hs, hs_idx;
    logic [1:0]       elig, grant;

    always_comb begin
        // A flushed S2 entry is about to vanish, so it never holds the pipe.
        stall     = vld_p2_q && !flush[own_p2_q] && !resp_ready[own_p2_q];
        accept_ok = !vld_p1_q || !stall;
        elig      = req_valid & ~flush;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        // Handshakes are blocked during reset so no request is silently dropped.
        req_ready = (accept_ok && !rst) ? grant : 2'b00;
        hs        = |req_ready;
        hs_idx    = req_ready[1];
        last_d    = hs ? hs_idx : last_q;

        vld_p2_d = vld_p2_q;
        own_p2_d = own_p2_q;
        res_p2_d = res_p2_q;
        tag_p2_d = tag_p2_q;
        if (!stall) begin
            vld_p2_d = vld_p1_q && !flush[own_p1_q];
            own_p2_d = own_p1_q;
            res_p2_d = mul(a_p1_q, b_p1_q, op_p1_q);
            tag_p2_d = tag_p1_q;
        end

        vld_p1_d = vld_p1_q && stall && !flush[own_p1_q];
        own_p1_d = own_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        op_p1_d  = op_p1_q;
        tag_p1_d = tag_p1_q;
        if (hs) begin
            vld_p1_d = 1'b1;
            own_p1_d = hs_idx;
            a_p1_d   = req_a[hs_idx];
            b_p1_d   = req_b[hs_idx];
            op_p1_d  = req_mulop[hs_idx];
            tag_p1_d = req_tag[hs_idx];
        end

        resp_valid    = 2'b00;
        resp_valid[0] = vld_p2_q && !own_p2_q && !flush[0] && !rst;
        resp_valid[1] = vld_p2_q &&  own_p2_q && !flush[1] && !rst;
        resp_data     = vld_p2_q ? res_p2_q : '0;
        resp_tag      = vld_p2_q ? tag_p2_q : '0;
    end

    // S1 and S2 stage boundaries; only valids and the arbiter pointer are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            last_q   <= last_d;
        end
        own_p1_q <= own_p1_d;
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        op_p1_q  <= op_p1_d;
        tag_p1_q <= tag_p1_d;
        own_p2_q <= own_p2_d;
        res_p2_q <= res_p2_d;
        tag_p2_q <= tag_p2_d;
    end
endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb: stimulus pushes hand-computed results into per-requester
// queues; a negedge monitor pops them on response handshakes and checks per-cycle expectations.
module tb_mul_arb;
    localparam logic [2:0] OP_MUL = 3'd0, OP_H = 3'd1, OP_HSU = 3'd2, OP_HU = 3'd3;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, flush, resp_valid, resp_ready;
    logic [1:0][31:0] req_a, req_b;
    logic [1:0][2:0] req_mulop;
    logic [1:0][4:0] req_tag;
    logic [31:0]     resp_data;
    logic [4:0]      resp_tag;

    logic [31:0] cur_exp [2];
    logic [1:0]  exp_rdy, exp_rv;
    logic        rdy_chk, rv_chk, zchk, fin_chk;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q [2][$];

    localparam logic [31:0] CA0 [4] = '{32'd1, 32'd3, 32'd3, 32'd6};
    localparam logic [4:0]  CT0 [4] = '{5'd10, 5'd11, 5'd11, 5'd12};
    localparam logic [31:0] CE0 [4] = '{32'd5, 32'd15, 32'd15, 32'd30};
    localparam logic [31:0] CA1 [4] = '{32'd2, 32'd2, 32'd4, 32'd4};
    localparam logic [4:0]  CT1 [4] = '{5'd20, 5'd20, 5'd21, 5'd21};
    localparam logic [31:0] CE1 [4] = '{32'd10, 32'd10, 32'd20, 32'd20};
    localparam logic [1:0]  CRDY [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic [1:0]  CRV  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};

    mul_arb #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mulop(req_mulop), .req_tag(req_tag),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        rdy_chk = 1'b0;
        rv_chk  = 1'b0;
        zchk    = 1'b0;
        fin_chk = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [4:0] tag, input logic [31:0] ex);
        req_valid[i] = 1'b1;
        req_a[i]     = a;
        req_b[i]     = b;
        req_mulop[i] = op;
        req_tag[i]   = tag;
        cur_exp[i]   = ex;
    endtask

    task automatic expect_cyc(input logic [1:0] rdy, input logic [1:0] rv);
        exp_rdy = rdy;
        exp_rv  = rv;
        rdy_chk = 1'b1;
        rv_chk  = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q[0].delete();
                q[1].delete();
            end else begin
                if (rdy_chk) begin
                    n_vec++;
                    if (req_ready !== exp_rdy) begin
                        n_err++;
                        $display("FAIL req_ready t=%0t got=%b want=%b", $time, req_ready, exp_rdy);
                    end
                end
                if (rv_chk) begin
                    n_vec++;
                    if (resp_valid !== exp_rv) begin
                        n_err++;
                        $display("FAIL resp_valid t=%0t got=%b want=%b", $time, resp_valid, exp_rv);
                    end
                end
                if (zchk) begin
                    n_vec++;
                    if (resp_data !== 32'd0 || resp_tag !== 5'd0) begin
                        n_err++;
                        $display("FAIL reset_outputs t=%0t got data=%h tag=%0d want 0/0",
                                 $time, resp_data, resp_tag);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (resp_valid[i] && resp_ready[i]) begin
                        n_vec++;
                        if (q[i].size() == 0) begin
                            n_err++;
                            $display("FAIL resp%0d_unexpected t=%0t got data=%h tag=%0d want none",
                                     i, $time, resp_data, resp_tag);
                        end else begin
                            e = q[i].pop_front();
                            if (resp_data !== e.d || resp_tag !== e.t) begin
                                n_err++;
                                $display("FAIL resp%0d_data t=%0t got data=%h tag=%0d want data=%h tag=%0d",
                                         i, $time, resp_data, resp_tag, e.d, e.t);
                            end
                        end
                    end
                    if (flush[i]) q[i].delete();
                    if (req_valid[i] && req_ready[i]) begin
                        e.d = cur_exp[i];
                        e.t = req_tag[i];
                        q[i].push_back(e);
                    end
                end
                if (fin_chk) begin
                    n_vec++;
                    if (q[0].size() + q[1].size() != 0) begin
                        n_err++;
                        $display("FAIL drain got pending=%0d/%0d want 0/0", q[0].size(), q[1].size());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = '0; flush = '0; resp_ready = 2'b11;
        req_a = '0; req_b = '0; req_mulop = '0; req_tag = '0;
        cur_exp[0] = '0; cur_exp[1] = '0; exp_rdy = '0; exp_rv = '0;
        rdy_chk = 0; rv_chk = 0; zchk = 0; fin_chk = 0;
        step(); step();
        rst = 1'b0; zchk = 1'b1; expect_cyc(2'b00, 2'b00); step();

        // Single ops and signed edges
        set_req(0, 32'hFFFF_FFFF, 32'd2, OP_HU, 5'd7, 32'h0000_0001); expect_cyc(2'b01, 2'b00); step();
        set_req(0, 32'hFFFF_FFFF, 32'd2, OP_H, 5'd8, 32'hFFFF_FFFF);  expect_cyc(2'b01, 2'b00); step();
        set_req(0, 32'hFFFF_FFFF, 32'd2, OP_MUL, 5'd9, 32'hFFFF_FFFE); expect_cyc(2'b01, 2'b01); step();
        req_valid = '0;
        set_req(1, 32'h8000_0000, 32'h8000_0000, OP_H, 5'd3, 32'h4000_0000); expect_cyc(2'b10, 2'b01); step();
        set_req(1, 32'h8000_0000, 32'h8000_0000, OP_HSU, 5'd4, 32'hC000_0000); expect_cyc(2'b10, 2'b01); step();
        req_valid = '0; expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b00); step();

        // Contention after reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_req(0, CA0[k], 32'd5, OP_MUL, CT0[k], CE0[k]);
                set_req(1, CA1[k], 32'd5, OP_MUL, CT1[k], CE1[k]);
            end else begin
                req_valid = '0;
            end
            expect_cyc(CRDY[k], CRV[k]);
            step();
        end

        // Backpressure on requester 1
        set_req(1, 32'd7, 32'd3, OP_MUL, 5'd1, 32'd21); expect_cyc(2'b10, 2'b00); step();
        set_req(1, 32'd8, 32'd3, OP_MUL, 5'd2, 32'd24); expect_cyc(2'b10, 2'b00); step();
        resp_ready = 2'b01;
        set_req(1, 32'd9, 32'd3, OP_MUL, 5'd3, 32'd27); expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b10); step();
        resp_ready = 2'b11; expect_cyc(2'b10, 2'b10); step();
        req_valid = '0; expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b00); step();
        // Stalled S2 with empty S1 still takes one request
        set_req(1, 32'd2, 32'd3, OP_MUL, 5'd5, 32'd6); expect_cyc(2'b10, 2'b00); step();
        req_valid = '0; expect_cyc(2'b00, 2'b00); step();
        resp_ready = 2'b01;
        set_req(1, 32'd3, 32'd3, OP_MUL, 5'd6, 32'd9); expect_cyc(2'b10, 2'b10); step();
        set_req(1, 32'd4, 32'd3, OP_MUL, 5'd7, 32'd12); expect_cyc(2'b00, 2'b10); step();
        resp_ready = 2'b11; expect_cyc(2'b10, 2'b10); step();
        req_valid = '0; expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b00); step();

        // Flush of requester 0 while requester 1 proceeds
        set_req(0, 32'd2, 32'd3, OP_MUL, 5'd12, 32'd6); expect_cyc(2'b01, 2'b00); step();
        set_req(0, 32'd3, 32'd3, OP_MUL, 5'd13, 32'd9); expect_cyc(2'b01, 2'b00); step();
        flush = 2'b01;
        set_req(0, 32'd4, 32'd3, OP_MUL, 5'd14, 32'd12);
        set_req(1, 32'd5, 32'd6, OP_MUL, 5'd15, 32'd30); expect_cyc(2'b10, 2'b00); step();
        req_valid[1] = 1'b0; expect_cyc(2'b00, 2'b00); step();
        flush = 2'b00; req_valid = '0; expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b00); step();

        // Reset with the pipeline full
        set_req(1, 32'd6, 32'd7, OP_MUL, 5'd16, 32'd42); expect_cyc(2'b10, 2'b00); step();
        req_valid[1] = 1'b0;
        set_req(0, 32'd7, 32'd7, OP_MUL, 5'd17, 32'd49); expect_cyc(2'b01, 2'b00); step();
        req_valid = '0; rst = 1'b1; step();
        rst = 1'b0; zchk = 1'b1; expect_cyc(2'b00, 2'b00); step();
        set_req(0, 32'd1, 32'd1, OP_MUL, 5'd18, 32'd1);
        set_req(1, 32'd2, 32'd2, OP_MUL, 5'd19, 32'd4); expect_cyc(2'b01, 2'b00); step();
        req_valid[0] = 1'b0; expect_cyc(2'b10, 2'b00); step();
        req_valid = '0; expect_cyc(2'b00, 2'b01); step();
        expect_cyc(2'b00, 2'b10); step();
        expect_cyc(2'b00, 2'b00); step();

        fin_chk = 1'b1; step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
